// File: rtl/line_window_buffer_pkg.sv
// Shared defaults and window indexing for the line window buffer.
// win_idx gives the LSB of window element (r,c) in the flattened output,
// with r=0 the oldest row and c=0 the leftmost column.
package line_window_buffer_pkg;

    localparam int unsigned DEFAULT_BITS        = 9;
    localparam int unsigned DEFAULT_KERNEL_SIZE = 3;

    function automatic int unsigned win_idx(
        input int unsigned r,
        input int unsigned c,
        input int unsigned k,
        input int unsigned bits
    );
        return (r * k + c) * bits;
    endfunction

endpackage

// File: rtl/line_window_buffer_line_delay.sv
// line_delay: DEPTH-deep, BITS-wide shift delay that advances only when en=1.
// Ports:
//   clk, reset : clock and synchronous active-high clear
//   en         : shift enable
//   din        : pixel entering the delay (entry 0 after the shift)
//   taps       : the first TAPS entries, entry 0 in the lowest BITS
//   dout       : the oldest entry (DEPTH-1)
module line_delay #(
    parameter int unsigned BITS  = 9,
    parameter int unsigned DEPTH = 16,
    parameter int unsigned TAPS  = 3
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   en,
    input  logic [BITS-1:0]        din,
    output logic [TAPS*BITS-1:0]   taps,
    output logic [BITS-1:0]        dout
);

    logic [BITS-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (en) begin
            mem[0] <= din;
            for (int unsigned i = 1; i < DEPTH; i++) begin
                mem[i] <= mem[i-1];
            end
        end
    end

    for (genvar t = 0; t < TAPS; t++) begin : g_tap
        assign taps[t*BITS +: BITS] = mem[t];
    end

    assign dout = mem[DEPTH-1];

endmodule

// File: rtl/line_window_buffer.sv
// line_window_buffer: raster-order pixel stream in, KxK sliding window out.
// Ports:
//   clk, reset    : clock and synchronous active-high reset
//   write_en      : accept serial_img_in on this edge
//   serial_img_in : raster-order pixel, top-left first
//   ready         : out holds a complete in-frame window this cycle
//   out           : flattened window, element (r,c) at win_idx(r,c)
//   frame_done    : one-cycle pulse after the last pixel of a frame
module line_window_buffer
    import line_window_buffer_pkg::*;
#(
    parameter int unsigned BITS        = DEFAULT_BITS,
    parameter int unsigned KERNEL_SIZE = DEFAULT_KERNEL_SIZE,
    parameter int unsigned IMG_LENGTH  = 16,
    parameter int unsigned IMG_HEIGHT  = 16
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic                                   write_en,
    input  logic [BITS-1:0]                        serial_img_in,
    output logic                                   ready,
    output logic [KERNEL_SIZE*KERNEL_SIZE*BITS-1:0] out,
    output logic                                   frame_done
);

    localparam int unsigned K  = KERNEL_SIZE;
    localparam int unsigned CW = $clog2(IMG_LENGTH);
    localparam int unsigned RW = $clog2(IMG_HEIGHT);

    localparam logic [CW-1:0] COL_LAST = CW'(IMG_LENGTH - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);
    localparam logic [CW-1:0] COL_WIN  = CW'(K - 1);
    localparam logic [RW-1:0] ROW_WIN  = RW'(K - 1);

    logic [CW-1:0]     col;
    logic [RW-1:0]     row;
    logic [BITS-1:0]   line_in   [K-1];
    logic [BITS-1:0]   line_out  [K-1];
    logic [K*BITS-1:0] line_taps [K-1];
    logic [BITS-1:0]   win_row   [K];

    // Chain: stage g holds pixels g*L .. g*L+L-1 acceptances old; the final
    // K-tap register holds the oldest window row at (K-1)*L .. (K-1)*L+K-1.
    for (genvar g = 0; g < K - 1; g++) begin : g_line
        if (g == 0) begin : g_first
            assign line_in[g] = serial_img_in;
        end else begin : g_next
            assign line_in[g] = line_out[g-1];
        end

        line_delay #(
            .BITS  (BITS),
            .DEPTH (IMG_LENGTH),
            .TAPS  (K)
        ) u_line (
            .clk   (clk),
            .reset (reset),
            .en    (write_en),
            .din   (line_in[g]),
            .taps  (line_taps[g]),
            .dout  (line_out[g])
        );
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < K; i++) begin
                win_row[i] <= '0;
            end
        end else if (write_en) begin
            win_row[0] <= line_out[K-2];
            for (int unsigned i = 1; i < K; i++) begin
                win_row[i] <= win_row[i-1];
            end
        end
    end

    // col/row name the pixel being accepted, so ready/frame_done are decided
    // from their pre-increment values.
    always_ff @(posedge clk) begin
        if (reset) begin
            col        <= '0;
            row        <= '0;
            ready      <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            ready      <= write_en && (row >= ROW_WIN) && (col >= COL_WIN);
            frame_done <= write_en && (row == ROW_LAST) && (col == COL_LAST);
            if (write_en) begin
                if (col == COL_LAST) begin
                    col <= '0;
                    row <= (row == ROW_LAST) ? '0 : row + RW'(1);
                end else begin
                    col <= col + CW'(1);
                end
            end
        end
    end

    // Row r of the window is r-from-top; the newest row (r=K-1) comes from
    // stage 0 and the oldest (r=0) from the K-tap register.
    always_comb begin
        out = '0;
        for (int unsigned r = 0; r < K; r++) begin
            for (int unsigned c = 0; c < K; c++) begin
                if (r == 0) begin
                    out[win_idx(r, c, K, BITS) +: BITS] = win_row[K-1-c];
                end else begin
                    out[win_idx(r, c, K, BITS) +: BITS] =
                        line_taps[K-1-r][(K-1-c)*BITS +: BITS];
                end
            end
        end
    end

endmodule

// File: tb/tb_line_window_buffer.sv
// Scoreboard bench for line_window_buffer with K=3, L=16, H=4, BITS=9.
module tb_line_window_buffer;

    localparam int unsigned BITS = 9;
    localparam int unsigned K    = 3;
    localparam int unsigned L    = 16;
    localparam int unsigned H    = 4;
    localparam int unsigned OW   = K*K*BITS;
    localparam int unsigned PER_FRAME = (L-K+1)*(H-K+1);

    logic            clk;
    logic            reset;
    logic            write_en;
    logic [BITS-1:0] serial_img_in;
    logic            ready;
    logic [OW-1:0]   out;
    logic            frame_done;

    line_window_buffer #(
        .BITS        (BITS),
        .KERNEL_SIZE (K),
        .IMG_LENGTH  (L),
        .IMG_HEIGHT  (H)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .write_en      (write_en),
        .serial_img_in (serial_img_in),
        .ready         (ready),
        .out           (out),
        .frame_done    (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [OW-1:0] win;
        logic          fd;
        int            base;
    } exp_t;

    exp_t q[$];
    int   hist[$];
    int   compared   = 0;
    int   mismatched = 0;
    int   brow = 0;
    int   bcol = 0;
    int   fr_cnt = 0;
    int   frame_base = 0;
    bit   mon_en = 0;

    // Hand-derived pixel offsets (from the frame's first value) of the first
    // and last window of a frame.
    int FIRST_OFS[9] = '{0, 1, 2, 16, 17, 18, 32, 33, 34};
    int LAST_OFS[9]  = '{29, 30, 31, 45, 46, 47, 61, 62, 63};

    function automatic logic [OW-1:0] pack_ofs(input int base, input int ofs[9]);
        logic [OW-1:0] w;
        w = '0;
        for (int i = 0; i < 9; i++) begin
            w[i*BITS +: BITS] = BITS'(base + ofs[i]);
        end
        return w;
    endfunction

    // Reference: window element (r,c) is the pixel accepted
    // (K-1-r)*L + (K-1-c) acceptances before the newest one.
    task automatic accept(input int pix);
        exp_t e;
        int   n;
        hist.push_back(pix);
        n = hist.size();
        if (brow >= K-1 && bcol >= K-1) begin
            e.win = '0;
            for (int r = 0; r < K; r++) begin
                for (int c = 0; c < K; c++) begin
                    e.win[(r*K+c)*BITS +: BITS] =
                        BITS'(hist[n-1-((K-1-r)*L + (K-1-c))]);
                end
            end
            e.fd   = (brow == H-1) && (bcol == L-1);
            e.base = frame_base;
            q.push_back(e);
        end
        if (bcol == L-1) begin
            bcol = 0;
            brow = (brow == H-1) ? 0 : brow + 1;
        end else begin
            bcol = bcol + 1;
        end
    endtask

    task automatic send(input int pix, input logic we);
        serial_img_in = BITS'(pix);
        write_en      = we;
        @(posedge clk);
        if (we) accept(pix);
        #1;
    endtask

    task automatic do_reset(input logic we, input int pix);
        reset         = 1'b1;
        write_en      = we;
        serial_img_in = BITS'(pix);
        @(posedge clk);
        brow   = 0;
        bcol   = 0;
        fr_cnt = 0;
        mon_en = 1;
        #1;
        reset    = 1'b0;
        write_en = 1'b0;
        compared++;
        if (out !== '0) begin
            mismatched++;
            $display("FAIL reset_out got=%h want=0", out);
        end
        compared++;
        if (ready !== 1'b0) begin
            mismatched++;
            $display("FAIL reset_ready got=%b want=0", ready);
        end
        compared++;
        if (frame_done !== 1'b0) begin
            mismatched++;
            $display("FAIL reset_frame_done got=%b want=0", frame_done);
        end
    endtask

    task automatic feed_frame(input int base, input int count, input bit gaps);
        frame_base = base;
        for (int i = 0; i < count; i++) begin
            if (gaps && (i % 2 == 1)) send(511, 1'b0);
            send(base + i, 1'b1);
        end
    endtask

    // Monitor: pops one expectation per ready pulse.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if (ready === 1'b1) begin
                    if (q.size() == 0) begin
                        compared++;
                        mismatched++;
                        $display("FAIL spurious_ready t=%0t ready=1 want=0", $time);
                    end else begin
                        e = q.pop_front();
                        compared++;
                        if (out !== e.win) begin
                            mismatched++;
                            $display("FAIL window t=%0t got=%h want=%h", $time, out, e.win);
                        end
                        compared++;
                        if (frame_done !== e.fd) begin
                            mismatched++;
                            $display("FAIL frame_done t=%0t got=%b want=%b", $time, frame_done, e.fd);
                        end
                        if (fr_cnt == 0) begin
                            compared++;
                            if (out !== pack_ofs(e.base, FIRST_OFS)) begin
                                mismatched++;
                                $display("FAIL first_window got=%h want=%h", out, pack_ofs(e.base, FIRST_OFS));
                            end
                        end
                        if (fr_cnt == PER_FRAME-1) begin
                            compared++;
                            if (out !== pack_ofs(e.base, LAST_OFS)) begin
                                mismatched++;
                                $display("FAIL last_window got=%h want=%h", out, pack_ofs(e.base, LAST_OFS));
                            end
                        end
                        fr_cnt++;
                        if (e.fd) begin
                            compared++;
                            if (fr_cnt != PER_FRAME) begin
                                mismatched++;
                                $display("FAIL ready_count got=%0d want=%0d", fr_cnt, PER_FRAME);
                            end
                            fr_cnt = 0;
                        end
                    end
                end else begin
                    if (q.size() != 0) begin
                        compared++;
                        mismatched++;
                        $display("FAIL missing_ready t=%0t ready=%b want=1", $time, ready);
                        void'(q.pop_front());
                    end
                    if (frame_done !== 1'b0) begin
                        compared++;
                        mismatched++;
                        $display("FAIL stray_frame_done t=%0t got=%b want=0", $time, frame_done);
                    end
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout compared=%0d", compared);
        $fatal(1, "timeout");
    end

    initial begin
        reset         = 1'b1;
        write_en      = 1'b0;
        serial_img_in = '0;
        @(posedge clk);
        #1;

        // Reset, then idle cycles with a non-zero pixel must not move the chain.
        do_reset(1'b0, 0);
        send(1, 1'b0);
        send(1, 1'b0);
        compared++;
        if (out !== '0) begin
            mismatched++;
            $display("FAIL idle_hold got=%h want=0", out);
        end

        // Continuous frame, then the same frame with idle gaps.
        feed_frame(0, 64, 1'b0);
        feed_frame(0, 64, 1'b1);

        // Reset mid-frame after pixel 40, then a full frame.
        feed_frame(0, 41, 1'b0);
        do_reset(1'b0, 0);
        feed_frame(0, 64, 1'b0);

        // Reset coinciding with write_en: pixel 99 must be discarded.
        do_reset(1'b1, 99);
        feed_frame(0, 64, 1'b0);

        // Back-to-back frames with new values.
        feed_frame(100, 64, 1'b0);
        feed_frame(200, 64, 1'b0);

        send(0, 1'b0);
        send(0, 1'b0);
        send(0, 1'b0);
        compared++;
        if (q.size() != 0) begin
            mismatched++;
            $display("FAIL pending_windows got=%0d want=0", q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
